// File: rtl/rr_arb4_funnel_pkg.sv
// arb_pkg: shared types and round-robin pick helper for the 4-source funnel
package arb_pkg;
  localparam int NUM_SRC = 4;
  typedef logic [1:0] src_idx_t;
  typedef enum logic {ST_IDLE, ST_LOCKED} arb_state_t;
  function automatic logic [NUM_SRC-1:0] rr_pick(input logic [NUM_SRC-1:0] req, input src_idx_t ptr);
    logic [NUM_SRC-1:0] g;
    src_idx_t idx;
    g = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = ptr + src_idx_t'(k);
      if (req[idx] && g == '0) g[idx] = 1'b1;
    end
    return g;
  endfunction
endpackage

// File: rtl/rr_arb4_funnel_mux4.sv
// Mux4: selects one WIDTH-bit lane of a packed 4-lane bus
module Mux4 #(
  parameter int WIDTH = 8
) (
  input  logic [4*WIDTH-1:0] i_data,
  input  logic [1:0]         i_sel,
  output logic [WIDTH-1:0]   o_data
);
  assign o_data = i_data[i_sel*WIDTH +: WIDTH];
endmodule

// File: rtl/rr_arb4_funnel.sv
// rr_arb4_funnel: round-robin 4:1 valid/ready arbiter with burst lock and a 1-entry output slot
module rr_arb4_funnel
  import arb_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         i_in_valid,
  input  logic [3:0]         i_in_last,
  input  logic [4*WIDTH-1:0] i_in_data,
  output logic [3:0]         o_in_ready,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [WIDTH-1:0]   o_out_data,
  output logic               o_out_last,
  output logic [1:0]         o_out_src
);
  arb_state_t       r_state;
  src_idx_t         r_owner, r_ptr, w_sel;
  logic             r_out_valid, r_out_last;
  logic [WIDTH-1:0] r_out_data, w_data;
  src_idx_t         r_out_src;
  logic [3:0]       w_grant;
  logic             w_load, w_accept, w_last;

  Mux4 #(.WIDTH(WIDTH)) u_mux (.i_data(i_in_data), .i_sel(w_sel), .o_data(w_data));

  // grant: locked owner only, otherwise round-robin after ptr; sel falls back to ptr when idle
  always_comb begin
    w_load     = !r_out_valid | i_out_ready;
    w_grant    = (r_state == ST_LOCKED) ? (i_in_valid & (4'b0001 << r_owner)) : rr_pick(i_in_valid, r_ptr);
    w_sel      = w_grant[0] ? 2'd0 : w_grant[1] ? 2'd1 : w_grant[2] ? 2'd2 : w_grant[3] ? 2'd3 : r_ptr;
    o_in_ready = w_load ? w_grant : 4'b0000;
    w_accept   = |o_in_ready;
    w_last     = i_in_last[w_sel];
  end

  // lock FSM, rr pointer and output slot advance together on each accepted beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_owner     <= 2'd0;
      r_ptr       <= 2'd3;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_src   <= 2'd0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_data;
      r_out_last  <= w_last;
      r_out_src   <= w_sel;
      r_state     <= w_last ? ST_IDLE : ST_LOCKED;
      r_owner     <= w_sel;
      if (w_last) r_ptr <= w_sel;
    end else if (w_load) begin
      r_out_valid <= 1'b0;
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_last  = r_out_last;
  assign o_out_src   = r_out_src;
endmodule

// File: tb/tb_rr_arb4_funnel.sv
// tb_rr_arb4_funnel: table vectors, directed corner sequences and random traffic against a behavioural model
module tb_rr_arb4_funnel;
  localparam int W = 8;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] iv = '0, il = '0, ir;
  logic [4*W-1:0] id = '0;
  logic ordy = 1'b0, ov, ol;
  logic [W-1:0] od;
  logic [1:0] os;
  int n_chk = 0, n_fail = 0;

  bit m_locked;
  int m_owner, m_ptr, m_os;
  bit m_ov, m_ol;
  logic [W-1:0] m_od;

  typedef struct {
    logic [3:0] v;
    logic [3:0] l;
    logic       rdy;
    logic [3:0] er;
    logic       eov;
    logic [1:0] es;
  } vec_t;
  vec_t tbl[7];

  rr_arb4_funnel #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .i_in_valid(iv), .i_in_last(il), .i_in_data(id),
    .o_in_ready(ir), .o_out_valid(ov), .i_out_ready(ordy), .o_out_data(od),
    .o_out_last(ol), .o_out_src(os)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_locked = 0; m_owner = 0; m_ptr = 3;
    m_ov = 0; m_od = '0; m_ol = 0; m_os = 0;
  endtask

  function automatic logic [3:0] m_grant();
    int idx;
    if (m_ov && !ordy) return 4'b0000;
    if (m_locked) return iv[m_owner] ? 4'(1 << m_owner) : 4'b0000;
    for (int k = 1; k <= 4; k++) begin
      idx = (m_ptr + k) % 4;
      if (iv[idx]) return 4'(1 << idx);
    end
    return 4'b0000;
  endfunction

  task automatic m_step();
    logic [3:0] g;
    int s;
    g = m_grant();
    s = -1;
    for (int k = 0; k < 4; k++) if (g[k]) s = k;
    if (s >= 0) begin
      m_ov = 1; m_od = id[s*W +: W]; m_ol = il[s]; m_os = s;
      if (il[s]) begin m_locked = 0; m_ptr = s; end
      else begin m_locked = 1; m_owner = s; end
    end else if (!m_ov || ordy) begin
      m_ov = 0;
    end
  endtask

  task automatic cyc();
    #1;
    chk("in_ready", 32'(ir), 32'(m_grant()));
    chk("out_valid", 32'(ov), 32'(m_ov));
    chk("out_data", 32'(od), 32'(m_od));
    chk("out_last", 32'(ol), 32'(m_ol));
    chk("out_src", 32'(os), 32'(m_os));
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic r);
    iv = v; il = l; ordy = r;
  endtask

  task automatic exp_ready(input string nm, input logic [3:0] e);
    #1 chk(nm, 32'(ir), 32'(e));
  endtask

  initial begin
    tbl[0] = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0};
    tbl[1] = '{4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0};
    tbl[2] = '{4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1};
    tbl[3] = '{4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2};
    tbl[4] = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3};
    tbl[5] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0};
    tbl[6] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
    id = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    m_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc();
    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].v, tbl[i].l, tbl[i].rdy);
      #1;
      chk($sformatf("tbl%0d_ready", i), 32'(ir), 32'(tbl[i].er));
      chk($sformatf("tbl%0d_ov", i), 32'(ov), 32'(tbl[i].eov));
      if (tbl[i].eov) chk($sformatf("tbl%0d_src", i), 32'(os), 32'(tbl[i].es));
      cyc();
    end
    drive(4'b0100, 4'b0000, 1'b1); exp_ready("lock_b1", 4'b0100); cyc();
    drive(4'b0110, 4'b0000, 1'b1); exp_ready("lock_b2", 4'b0100); cyc();
    drive(4'b0110, 4'b0100, 1'b1); exp_ready("lock_b3", 4'b0100); cyc();
    drive(4'b0010, 4'b0000, 1'b1); exp_ready("lock_next", 4'b0010); cyc();
    drive(4'b0010, 4'b0010, 1'b1); cyc();
    drive(4'b0001, 4'b0001, 1'b1); cyc();
    ordy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_ready", 32'(ir), 32'h0);
      chk("bp_src", 32'(os), 32'h0);
      chk("bp_ov", 32'(ov), 32'h1);
      cyc();
    end
    ordy = 1'b1; exp_ready("bp_release", 4'b0001); cyc();
    drive(4'b0000, 4'b0000, 1'b1); cyc();
    drive(4'b1000, 4'b1000, 1'b1); cyc();
    drive(4'b1001, 4'b1001, 1'b1); exp_ready("wrap_src0", 4'b0001); cyc();
    exp_ready("wrap_src3", 4'b1000); cyc();
    drive(4'b0000, 4'b0000, 1'b1); cyc();
    drive(4'b0010, 4'b0000, 1'b1); cyc();
    #1 chk("pre_rst_ov", 32'(ov), 32'h1);
    rst_n = 1'b0;
    #1 chk("rst_ov", 32'(ov), 32'h0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b0011, 4'b0011, 1'b1); exp_ready("post_rst_src0", 4'b0001); cyc();
    drive(4'b0000, 4'b0000, 1'b1); cyc();
    drive(4'b0100, 4'b0000, 1'b1); cyc();
    for (int i = 0; i < 5; i++) begin
      drive(4'b0001, 4'b0001, 1'b1); exp_ready("idle_owner", 4'b0000); cyc();
    end
    drive(4'b0100, 4'b0100, 1'b1); cyc();
    for (int i = 0; i < 400; i++) begin
      iv = 4'($urandom);
      il = 4'($urandom) & 4'($urandom);
      ordy = ($urandom % 4) != 0;
      id = 32'($urandom);
      cyc();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
